vector_alu_issue_ctrl: RTL and testbench
========================================

// Module: vector_alu_issue_ctrl
// PURPOSE
//   Issue/writeback controller that drives the 64-bit vector ALU (R, S, ALU_Op in; Y out).
//   Accepts one command per transaction on a valid/ready interface and reads two operands
//   from a 16x64 register file. Drives the ALU for a fixed settle window, captures Y,
//   writes it back and returns it on a valid/ready response port.
// PARAMETERS
//   EXEC_CYC  2   cycles alu_* are held stable before Y is sampled (1..15); covers MUL path
//   NREGS     16  register-file depth; r0 reads 0, writes to r0 are discarded
// PORTS
//   clk         in   1   single clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   cmd_valid   in   1   command present
//   cmd_ready   out  1   controller can accept a command
//   cmd_op      in   5   ALU opcode, forwarded to alu_op
//   cmd_rd      in   4   destination register
//   cmd_ra      in   4   source register -> alu_r
//   cmd_rb      in   4   source register -> alu_s (ignored when cmd_use_imm=1)
//   cmd_use_imm in   1   1: alu_s = cmd_imm instead of reg[cmd_rb]
//   cmd_imm     in   64  immediate operand
//   alu_r       out  64  to ALU R, registered
//   alu_s       out  64  to ALU S, registered
//   alu_op      out  5   to ALU ALU_Op, registered
//   alu_y       in   64  from ALU Y
//   rsp_valid   out  1   result available
//   rsp_ready   in   1   consumer accepts result
//   rsp_data    out  64  captured result
//   rsp_rd      out  4   destination register of the result
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; cmd_ready=0 while rst=1, 1 on the first cycle after;
//     alu_r/alu_s=0; alu_op=5'b11111 (ALU hold); rsp_valid=0; rsp_data=0; rsp_rd=0;
//     regfile cleared. Reset mid-transaction abandons it: no writeback, no response.
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge T: register alu_r=reg[ra],
//     alu_s=use_imm?imm:reg[rb], alu_op=cmd_op, latch rd; cnt=EXEC_CYC-1; go EXEC.
//   EXEC: cmd_ready=0; alu_* held constant. cnt decrements each cycle. At the edge where
//     cnt==0: rsp_data<=alu_y, rsp_rd<=rd; reg[rd]<=alu_y unless rd==0 or op==5'b11111;
//     go RESP.
//   RESP: rsp_valid=1; rsp_data/rsp_rd stable until rsp_valid&&rsp_ready, then IDLE,
//     alu_op<=5'b11111.
//   Latency: accept edge T -> rsp_valid high after edge T+EXEC_CYC. Throughput: one
//     command per EXEC_CYC+2 cycles when rsp_ready is held high.
//   Op 5'b11111 (hold): no writeback; rsp_data=0 and a response is still issued.
//   Op 5'b01001 (MUL MSW): forwarded unchanged; controller adds no special handling.
//   Operand read hazard: none, single outstanding command; a write in EXEC is visible to
//     the next accepted command.
//   r0: reads always return 0 on both ports; a write to rd=0 still yields a response.
//   cmd_* are sampled only on the accept edge; changes at other times are ignored.
//   Widths: all datapaths 64 bits, no extension; the controller does not inspect results.
// STRUCTURE
//   Shared package alu_pkg: localparams for all 5-bit opcodes (ADD=00000, PASS_S=00001,
//     SUB=00010, AND=00011, OR=00100, XOR=00101, ADDS=00110, SUBS=00111, MUL=01000,
//     MULH=01001, CMP=01010, HOLD=11111), FSM state encodings, and NREGS.
//   One sub-module: alu_regfile (NREGS x 64, 2 async read ports, 1 sync write port,
//     r0 forced to zero, async clear on rst).
// TESTING
//   1 Reset then load: {PASS_S, rd=1, imm=64'h5} -> rsp_data=5 at T+EXEC_CYC+1; reg1=5.
//   2 r1=5, r2=3, {SUB, rd=3, ra=1, rb=2} -> alu_op=00010 held EXEC_CYC cycles; rsp_data=2.
//   3 rsp_ready=0 for 5 cycles -> rsp_valid stays 1, data stable, cmd_ready=0 throughout.
//   4 {PASS_S, rd=0, imm=7} -> response 7; next {ADD, ra=0, rb=0} -> rsp_data=0.
//   5 Assert rst in EXEC -> outputs at reset values immediately; target reg unchanged,
//     no rsp_valid.
//   6 {HOLD, rd=4} with reg4=9 -> rsp_data=0; reg4 still 9; back-to-back commands
//     accepted every EXEC_CYC+2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the vector ALU issue/writeback controller:
// opcodes, FSM states and register-file geometry.
package alu_pkg;
  localparam int DATA_W = 64;
  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_PASS_S = 5'b00001;
  localparam logic [4:0] OP_SUB    = 5'b00010;
  localparam logic [4:0] OP_AND    = 5'b00011;
  localparam logic [4:0] OP_OR     = 5'b00100;
  localparam logic [4:0] OP_XOR    = 5'b00101;
  localparam logic [4:0] OP_ADDS   = 5'b00110;
  localparam logic [4:0] OP_SUBS   = 5'b00111;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_CMP    = 5'b01010;
  localparam logic [4:0] OP_HOLD   = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/vector_alu_issue_ctrl_if.sv
// Command, ALU and response signals of the issue controller.
// The slave side is the controller; the master side is its environment.
interface vector_alu_issue_ctrl_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_ra;
  logic [REG_AW-1:0] cmd_rb;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;

  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] alu_s;
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] alu_y;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [REG_AW-1:0] rsp_rd;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output alu_r, alu_s, alu_op,
    input  alu_y,
    output rsp_valid, rsp_data, rsp_rd,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  alu_r, alu_s, alu_op,
    output alu_y,
    input  rsp_valid, rsp_data, rsp_rd,
    output rsp_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// NREGS x 64 register file: two asynchronous read ports, one synchronous
// write port, r0 hard-wired to zero, contents cleared by reset.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];
endmodule

// File: rtl/vector_alu_issue_ctrl.sv
// Issue/writeback controller for the 64-bit vector ALU: one command in flight,
// operands held on the ALU for EXEC_CYC cycles, result written back and returned.
module vector_alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int EXEC_CYC = 2
) (
  input logic                   clk,
  input logic                   rst,
  vector_alu_issue_ctrl_if.slave bus
);
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic              accept, done, release_rsp, wb_en;

  alu_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (bus.cmd_ra),
    .rb_addr (bus.cmd_rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (wb_en),
    .wa      (rd_q),
    .wd      (bus.alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // cmd_ready is masked by rst so nothing is accepted while reset is held
  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    done          = 1'b0;
    release_rsp   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = !rst;
        if (bus.cmd_valid && !rst) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          release_rsp = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // HOLD suppresses writeback and returns zero whatever the ALU drives
  assign wb_en = done && (bus.alu_op != OP_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_r    <= '0;
      bus.alu_s    <= '0;
      bus.alu_op   <= OP_HOLD;
      bus.rsp_data <= '0;
      bus.rsp_rd   <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        bus.alu_r  <= ra_data;
        bus.alu_s  <= bus.cmd_use_imm ? bus.cmd_imm : rb_data;
        bus.alu_op <= bus.cmd_op;
        rd_q       <= bus.cmd_rd;
        cnt_q      <= CNT_INIT;
      end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (done) begin
        bus.rsp_data <= (bus.alu_op == OP_HOLD) ? '0 : bus.alu_y;
        bus.rsp_rd   <= rd_q;
      end
      if (release_rsp) bus.alu_op <= OP_HOLD;
    end
  end
endmodule

// File: tb/tb_vector_alu_issue_ctrl.sv
// Bench for vector_alu_issue_ctrl: directed scenarios plus random commands,
// checked every cycle against a transaction-level model of the controller.
`timescale 1ns/1ps
module tb_vector_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int EXEC_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_alu_issue_ctrl_if bus ();

  vector_alu_issue_ctrl #(.EXEC_CYC(EXEC_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in ALU; HOLD drives a non-zero pattern the controller must not return
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [63:0] r,
                                         input logic [63:0] s);
    logic [127:0] p;
    p = {64'd0, r} * {64'd0, s};
    case (op)
      OP_ADD:    return r + s;
      OP_PASS_S: return s;
      OP_SUB:    return r - s;
      OP_AND:    return r & s;
      OP_OR:     return r | s;
      OP_XOR:    return r ^ s;
      OP_ADDS:   return r + s + 64'd1;
      OP_SUBS:   return s - r;
      OP_MUL:    return p[63:0];
      OP_MULH:   return p[127:64];
      OP_CMP:    return ($signed(r) < $signed(s)) ? 64'd1 : 64'd0;
      default:   return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  assign bus.alu_y = alu_fn(bus.alu_op, bus.alu_r, bus.alu_s);

  // Transaction-level model: busy/resp flags, cycle count since accept, register array
  logic [63:0] m_regs [16];
  bit          m_busy, m_resp;
  int          m_n;
  logic [63:0] m_alu_r, m_alu_s, m_rsp_data;
  logic [4:0]  m_alu_op;
  logic [3:0]  m_rd, m_rsp_rd;

  function automatic logic [63:0] m_read(input logic [3:0] a);
    return (a == 4'd0) ? 64'd0 : m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
    m_busy = 0; m_resp = 0; m_n = 0;
    m_alu_r = 64'd0; m_alu_s = 64'd0; m_alu_op = OP_HOLD;
    m_rsp_data = 64'd0; m_rsp_rd = 4'd0; m_rd = 4'd0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else if (!m_busy) begin
        if (bus.cmd_valid) begin
          m_alu_r  = m_read(bus.cmd_ra);
          m_alu_s  = bus.cmd_use_imm ? bus.cmd_imm : m_read(bus.cmd_rb);
          m_alu_op = bus.cmd_op;
          m_rd     = bus.cmd_rd;
          m_busy   = 1;
          m_n      = 0;
        end
      end else if (!m_resp) begin
        m_n++;
        if (m_n == EXEC_CYC) begin
          m_rsp_data = (m_alu_op == OP_HOLD) ? 64'd0 : alu_fn(m_alu_op, m_alu_r, m_alu_s);
          m_rsp_rd   = m_rd;
          if (m_rd != 4'd0 && m_alu_op != OP_HOLD) m_regs[m_rd] = m_rsp_data;
          m_resp = 1;
        end
      end else if (bus.rsp_ready) begin
        m_busy   = 0;
        m_resp   = 0;
        m_alu_op = OP_HOLD;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(!m_busy && !rst));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_resp));
      chk("alu_op",    64'(bus.alu_op),    64'(m_alu_op));
      chk("alu_r",     bus.alu_r,          m_alu_r);
      chk("alu_s",     bus.alu_s,          m_alu_s);
      chk("rsp_data",  bus.rsp_data,       m_rsp_data);
      chk("rsp_rd",    64'(bus.rsp_rd),    64'(m_rsp_rd));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns the time of the accepting edge
  task automatic do_cmd(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                        input logic [3:0] rb, input logic ui, input logic [63:0] imm,
                        output time t_acc);
    int   k;
    logic rdy;
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_ra = ra; bus.cmd_rb = rb;
    bus.cmd_use_imm = ui; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      rdy = bus.cmd_ready;
      @(posedge clk);
      k++;
    end while (!rdy && k < 100);
    t_acc = $time;
    if (!rdy) chk("accept_timeout", 64'd0, 64'd1);
    #1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 5'($urandom);
    bus.cmd_rd      = 4'($urandom);
    bus.cmd_ra      = 4'($urandom);
    bus.cmd_rb      = 4'($urandom);
    bus.cmd_use_imm = 1'($urandom);
    bus.cmd_imm     = {$urandom, $urandom};
  endtask

  // Counts falling edges until rsp_valid; completes the handshake if rsp_ready is high
  task automatic wait_rsp(output int lat, output logic [63:0] data);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    if (!bus.rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    data = bus.rsp_data;
    if (bus.rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_random();
    int k;
    bit fin;
    k = 0; fin = 0;
    while (!fin && k < 300) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) fin = 1;
      @(posedge clk);
      #1;
      k++;
    end
    if (!fin) chk("drain_timeout", 64'd0, 64'd1);
    bus.rsp_ready = 1'b1;
  endtask

  logic [4:0] ops [12] = '{OP_ADD, OP_PASS_S, OP_SUB, OP_AND, OP_OR, OP_XOR,
                           OP_ADDS, OP_SUBS, OP_MUL, OP_MULH, OP_CMP, OP_HOLD};

  initial begin
    time         t0, t1;
    int          lat;
    logic [63:0] d;

    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 5'd0; bus.cmd_rd = 4'd0; bus.cmd_ra = 4'd0;
    bus.cmd_rb = 4'd0; bus.cmd_use_imm = 1'b0; bus.cmd_imm = 64'd0; bus.rsp_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_alu_op",    64'(bus.alu_op),    64'h1f);
    chk("rst_rsp_data",  bus.rsp_data,       64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;

    // Load and latency
    do_cmd(OP_PASS_S, 4'd1, 4'd0, 4'd0, 1'b1, 64'h5, t0);
    wait_rsp(lat, d);
    chk("t1_latency", 64'(lat), 64'(EXEC_CYC + 1));
    chk("t1_data", d, 64'h5);

    // SUB with operands held for the whole execute window
    do_cmd(OP_PASS_S, 4'd2, 4'd0, 4'd0, 1'b1, 64'h3, t0);
    wait_rsp(lat, d);
    do_cmd(OP_SUB, 4'd3, 4'd1, 4'd2, 1'b0, 64'hFFFF, t0);
    for (int i = 0; i < EXEC_CYC; i++) begin
      @(negedge clk);
      chk("t2_alu_op", 64'(bus.alu_op), 64'(5'b00010));
      chk("t2_alu_r",  bus.alu_r, 64'd5);
      chk("t2_alu_s",  bus.alu_s, 64'd3);
    end
    wait_rsp(lat, d);
    chk("t2_latency", 64'(lat), 64'd1);
    chk("t2_data", d, 64'd2);

    // Back-pressure on the response
    bus.rsp_ready = 1'b0;
    do_cmd(OP_ADD, 4'd6, 4'd1, 4'd2, 1'b0, 64'd0, t0);
    wait_rsp(lat, d);
    chk("t3_data", d, 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid_held", 64'(bus.rsp_valid), 64'd1);
      chk("t3_data_held",  bus.rsp_data, 64'd8);
      chk("t3_rd_held",    64'(bus.rsp_rd), 64'd6);
      chk("t3_not_ready",  64'(bus.cmd_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_released", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;

    // r0 discards writes and reads zero
    do_cmd(OP_PASS_S, 4'd0, 4'd0, 4'd0, 1'b1, 64'h7, t0);
    wait_rsp(lat, d);
    chk("t4_rd0_rsp", d, 64'h7);
    do_cmd(OP_ADD, 4'd7, 4'd0, 4'd0, 1'b0, 64'h1234, t0);
    wait_rsp(lat, d);
    chk("t4_r0_reads_zero", d, 64'd0);

    // HOLD: zero result, no writeback, back-to-back throughput
    do_cmd(OP_PASS_S, 4'd4, 4'd0, 4'd0, 1'b1, 64'h9, t0);
    wait_rsp(lat, d);
    do_cmd(OP_HOLD, 4'd4, 4'd4, 4'd4, 1'b0, 64'd0, t0);
    wait_rsp(lat, d);
    chk("t6_hold_data", d, 64'd0);
    do_cmd(OP_ADD, 4'd5, 4'd4, 4'd0, 1'b0, 64'd0, t1);
    chk("t6_throughput", 64'((t1 - t0) / 10), 64'(EXEC_CYC + 2));
    wait_rsp(lat, d);
    chk("t6_reg4_kept", d, 64'h9);

    // Reset in the middle of execution
    do_cmd(OP_PASS_S, 4'd8, 4'd0, 4'd0, 1'b1, 64'h55, t0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t5_alu_op",    64'(bus.alu_op),    64'h1f);
    chk("t5_alu_r",     bus.alu_r,          64'd0);
    chk("t5_alu_s",     bus.alu_s,          64'd0);
    chk("t5_rsp_data",  bus.rsp_data,       64'd0);
    chk("t5_rsp_rd",    64'(bus.rsp_rd),    64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2 * EXEC_CYC + 2; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    do_cmd(OP_ADD, 4'd9, 4'd8, 4'd4, 1'b0, 64'd0, t0);
    wait_rsp(lat, d);
    chk("t5_regs_cleared", d, 64'd0);

    // Random commands with random gaps and response back-pressure
    for (int n = 0; n < 200; n++) begin
      logic [4:0] op;
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) op = OP_PASS_S;
      do_cmd(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
             {$urandom, $urandom}, t0);
      drain_random();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
